// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// tomasulo_pkg : shared opcodes, tag width and CDB result-entry type
// Rev 1.0
// ============================================================================
package tomasulo_pkg;

  localparam int TAGW = 7;

  localparam logic [5:0] c_op_add  = 6'd0;
  localparam logic [5:0] c_op_sub  = 6'd1;
  localparam logic [5:0] c_op_sll  = 6'd2;
  localparam logic [5:0] c_op_slt  = 6'd3;
  localparam logic [5:0] c_op_sltu = 6'd4;
  localparam logic [5:0] c_op_xor  = 6'd5;
  localparam logic [5:0] c_op_srl  = 6'd6;
  localparam logic [5:0] c_op_sra  = 6'd7;
  localparam logic [5:0] c_op_or   = 6'd8;
  localparam logic [5:0] c_op_and  = 6'd9;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     value;
    logic            illegal;
  } cdb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rtype_alu.sv
`default_nettype none
// ============================================================================
// rtype_alu : combinational RV32I R-type ALU; undefined opcodes flag illegal
// Rev 1.0
// ============================================================================
module rtype_alu
  import tomasulo_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] value,
  output logic        illegal
);

  logic [4:0] w_shamt;
  assign w_shamt = src2[4:0];

  always_comb begin
    value   = 32'd0;
    illegal = 1'b0;
    case (op)
      c_op_add:  value = src1 + src2;
      c_op_sub:  value = src1 - src2;
      c_op_sll:  value = src1 << w_shamt;
      c_op_slt:  value = {31'd0, ($signed(src1) < $signed(src2))};
      c_op_sltu: value = {31'd0, (src1 < src2)};
      c_op_xor:  value = src1 ^ src2;
      c_op_srl:  value = src1 >> w_shamt;
      c_op_sra:  value = $unsigned($signed(src1) >>> w_shamt);
      c_op_or:   value = src1 | src2;
      c_op_and:  value = src1 & src2;
      default:   illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rtype_exec_unit.sv
`default_nettype none
// ============================================================================
// rtype_exec_unit : one-stage R-type execute with 2-entry CDB result queue
// Rev 1.0
// ============================================================================
module rtype_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TAGW   = tomasulo_pkg::TAGW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            is_to_execute,
  output logic            issue_ready,
  input  logic [5:0]      is_ex_instruction,
  input  logic [31:0]     is_ex_src1,
  input  logic [31:0]     is_ex_src2,
  input  logic [TAGW-1:0] is_ex_dest_tag,
  output logic            cdb_valid,
  input  logic            cdb_grant,
  output logic [TAGW-1:0] cdb_tag,
  output logic [31:0]     cdb_value,
  output logic            cdb_illegal,
  output logic [15:0]     ops_done
);

  localparam int c_ptr_w = $clog2(QDEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w:0] c_depth = QDEPTH[c_cnt_w:0];

  logic              r_ex1_valid;
  logic [5:0]        r_ex1_op;
  logic [31:0]       r_ex1_src1;
  logic [31:0]       r_ex1_src2;
  logic [TAGW-1:0]   r_ex1_tag;

  cdb_entry_t        r_queue [QDEPTH];
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_cnt_w-1:0] r_count;
  logic [15:0]        r_ops_done;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [c_cnt_w:0]  w_occupancy;
  logic [31:0]       w_alu_value;
  logic              w_alu_illegal;
  cdb_entry_t        w_head;

  rtype_alu u_alu (
    .op      (r_ex1_op),
    .src1    (r_ex1_src1),
    .src2    (r_ex1_src2),
    .value   (w_alu_value),
    .illegal (w_alu_illegal)
  );

  // A same-cycle grant frees a slot, so it counts toward this cycle's credit.
  assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_ex1_valid}
                     - {{c_cnt_w{1'b0}}, w_pop};
  assign issue_ready = reset_n && (w_occupancy < c_depth);
  assign w_accept    = is_to_execute && issue_ready;
  assign w_push      = r_ex1_valid;
  assign w_pop       = cdb_valid && cdb_grant;

  // Queue storage is never cleared, so the head is masked while empty.
  assign w_head      = r_queue[r_rptr];
  assign cdb_valid   = (r_count != '0);
  assign cdb_tag     = cdb_valid ? w_head.tag     : '0;
  assign cdb_value   = cdb_valid ? w_head.value   : 32'd0;
  assign cdb_illegal = cdb_valid ? w_head.illegal : 1'b0;
  assign ops_done    = r_ops_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ex1_valid <= 1'b0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_ops_done  <= 16'd0;
    end else begin
      r_ex1_valid <= w_accept;
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + c_ptr_w'(1);
        r_ops_done <= r_ops_done + 16'd1;
      end
      r_count <= r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_ex1_op   <= is_ex_instruction;
      r_ex1_src1 <= is_ex_src1;
      r_ex1_src2 <= is_ex_src2;
      r_ex1_tag  <= is_ex_dest_tag;
    end
    if (w_push) begin
      r_queue[r_wptr] <= '{tag: r_ex1_tag, value: w_alu_value, illegal: w_alu_illegal};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtype_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_rtype_exec_unit : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ============================================================================
module tb_rtype_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        is_to_execute;
  logic        issue_ready;
  logic [5:0]  is_ex_instruction;
  logic [31:0] is_ex_src1;
  logic [31:0] is_ex_src2;
  logic [6:0]  is_ex_dest_tag;
  logic        cdb_valid;
  logic        cdb_grant;
  logic [6:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_illegal;
  logic [15:0] ops_done;

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  tag;
    logic [31:0] value;
    logic        illegal;
  } vec_t;

  vec_t vecs [12];

  rtype_exec_unit dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .is_to_execute     (is_to_execute),
    .issue_ready       (issue_ready),
    .is_ex_instruction (is_ex_instruction),
    .is_ex_src1        (is_ex_src1),
    .is_ex_src2        (is_ex_src2),
    .is_ex_dest_tag    (is_ex_dest_tag),
    .cdb_valid         (cdb_valid),
    .cdb_grant         (cdb_grant),
    .cdb_tag           (cdb_tag),
    .cdb_value         (cdb_value),
    .cdb_illegal       (cdb_illegal),
    .ops_done          (ops_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] tag);
    is_to_execute     = 1'b1;
    is_ex_instruction = op;
    is_ex_src1        = a;
    is_ex_src2        = b;
    is_ex_dest_tag    = tag;
  endtask

  initial begin
    vecs[0]  = '{6'd0,  32'h7FFFFFFF, 32'h00000001, 7'd5,   32'h80000000, 1'b0};
    vecs[1]  = '{6'd1,  32'h00000000, 32'h00000001, 7'd6,   32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{6'd2,  32'h00000003, 32'h00000024, 7'd7,   32'h00000030, 1'b0};
    vecs[3]  = '{6'd3,  32'hFFFFFFFF, 32'h00000001, 7'd8,   32'h00000001, 1'b0};
    vecs[4]  = '{6'd4,  32'hFFFFFFFF, 32'h00000001, 7'd9,   32'h00000000, 1'b0};
    vecs[5]  = '{6'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 7'd10,  32'hFF00FF00, 1'b0};
    vecs[6]  = '{6'd6,  32'h80000000, 32'h00000024, 7'd11,  32'h08000000, 1'b0};
    vecs[7]  = '{6'd7,  32'h80000000, 32'h00000024, 7'd12,  32'hF8000000, 1'b0};
    vecs[8]  = '{6'd8,  32'h12340000, 32'h00005678, 7'd13,  32'h12345678, 1'b0};
    vecs[9]  = '{6'd9,  32'hFFFF0000, 32'h0F0F0F0F, 7'd14,  32'h0F0F0000, 1'b0};
    vecs[10] = '{6'h3F, 32'h12345678, 32'h9ABCDEF0, 7'h7F,  32'h00000000, 1'b1};
    vecs[11] = '{6'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'h40,  32'h00000000, 1'b1};

    // Reset with an issue presented: must be ignored.
    reset_n   = 1'b0;
    cdb_grant = 1'b1;
    drive(6'd0, 32'd1, 32'd2, 7'd99);
    repeat (3) begin
      @(negedge clock);
      check("rst_issue_ready", 32'(issue_ready), 32'd0);
    end
    check("rst_cdb_valid",   32'(cdb_valid),   32'd0);
    check("rst_cdb_tag",     32'(cdb_tag),     32'd0);
    check("rst_cdb_value",   cdb_value,        32'd0);
    check("rst_cdb_illegal", 32'(cdb_illegal), 32'd0);
    check("rst_ops_done",    32'(ops_done),    32'd0);
    reset_n       = 1'b1;
    is_to_execute = 1'b0;
    #1 check("rst_release_ready", 32'(issue_ready), 32'd1);
    repeat (2) @(negedge clock);
    check("rst_no_ghost_valid", 32'(cdb_valid), 32'd0);

    // Vector table, grant held high.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      check($sformatf("v%0d_ready", i), 32'(issue_ready), 32'd1);
      @(negedge clock);
      is_to_execute = 1'b0;
      check($sformatf("v%0d_lat_valid0", i), 32'(cdb_valid), 32'd0);
      @(negedge clock);
      check($sformatf("v%0d_valid", i),   32'(cdb_valid),   32'd1);
      check($sformatf("v%0d_tag", i),     32'(cdb_tag),     32'(vecs[i].tag));
      check($sformatf("v%0d_value", i),   cdb_value,        vecs[i].value);
      check($sformatf("v%0d_illegal", i), 32'(cdb_illegal), 32'(vecs[i].illegal));
      exp_ops++;
      @(negedge clock);
      check($sformatf("v%0d_ops_done", i), 32'(ops_done), 32'(exp_ops));
      check($sformatf("v%0d_drained", i),  32'(cdb_valid), 32'd0);
    end

    // Backpressure: four back-to-back offers, only two fit.
    cdb_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(6'd0, 32'd100 + 32'(k), 32'd0, 7'(10 + k));
      check($sformatf("bp_ready%0d", k), 32'(issue_ready), (k < 2) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    is_to_execute = 1'b0;
    check("bp_valid_held", 32'(cdb_valid),   32'd1);
    check("bp_tag_first",  32'(cdb_tag),     32'd10);
    check("bp_ready_full", 32'(issue_ready), 32'd0);
    @(negedge clock);
    check("bp_tag_stable",   32'(cdb_tag),   32'd10);
    check("bp_value_stable", cdb_value,      32'd100);
    cdb_grant = 1'b1;
    #1 check("bp_reopen_same_cycle", 32'(issue_ready), 32'd1);
    @(negedge clock);
    check("bp_second_valid", 32'(cdb_valid), 32'd1);
    check("bp_second_tag",   32'(cdb_tag),   32'd11);
    check("bp_second_value", cdb_value,      32'd101);
    exp_ops += 2;
    @(negedge clock);
    check("bp_empty",    32'(cdb_valid), 32'd0);
    check("bp_ops_done", 32'(ops_done),  32'(exp_ops));

    // Reset with one result queued and another in EX1.
    cdb_grant = 1'b0;
    @(negedge clock);
    drive(6'd0, 32'd30, 32'd0, 7'd30);
    @(negedge clock);
    drive(6'd0, 32'd31, 32'd0, 7'd31);
    @(negedge clock);
    is_to_execute = 1'b0;
    check("mr_pre_valid", 32'(cdb_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("mr_valid",    32'(cdb_valid),   32'd0);
    check("mr_ops_done", 32'(ops_done),    32'd0);
    check("mr_ready",    32'(issue_ready), 32'd0);
    reset_n   = 1'b1;
    cdb_grant = 1'b1;
    exp_ops   = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("mr_no_stale%0d", k), 32'(cdb_valid), 32'd0);
    end
    check("mr_ops_after", 32'(ops_done), 32'd0);

    // Throughput: ten consecutive issues, results on consecutive cycles.
    begin
      int seen = 0;
      for (int k = 0; k < 14; k++) begin
        @(negedge clock);
        if (k < 10) begin
          drive(6'd0, 32'(k * 3), 32'd1, 7'(20 + k));
          check($sformatf("tp_ready%0d", k), 32'(issue_ready), 32'd1);
        end else begin
          is_to_execute = 1'b0;
        end
        check($sformatf("tp_valid%0d", k), 32'(cdb_valid), (k >= 2 && k <= 11) ? 32'd1 : 32'd0);
        if (cdb_valid) begin
          check($sformatf("tp_tag%0d", k),   32'(cdb_tag), 32'(20 + seen));
          check($sformatf("tp_value%0d", k), cdb_value,    32'(seen * 3 + 1));
          seen++;
        end
      end
      check("tp_count",    32'(seen),     32'd10);
      check("tp_ops_done", 32'(ops_done), 32'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
